// File: rtl/fa_bist_checker_pkg.sv
// Shared types and sizes for the full-adder BIST checker.
// Holds the FSM state encoding, vector count, counter widths and the stimulus payload.
package fa_bist_checker_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned ERR_W       = 4;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stimulus applied to the adder under test; bit order matches {a,b,cin} = idx.
    typedef struct packed {
        logic a;
        logic b;
        logic cin;
    } fa_vec_t;

    function automatic fa_vec_t idx_to_vec(input logic [IDX_W-1:0] idx);
        return fa_vec_t'(idx);
    endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Golden full-adder: expected {cout,sum} for the current stimulus vector.
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic [1:0] total_c;

    assign total_c = 2'(a) + 2'(b) + 2'(cin);
    assign sum     = total_c[0];
    assign cout    = total_c[1];

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive 8-vector BIST for an external full adder: drives stimulus, holds each
// vector SETTLE cycles, compares the response and records error count / first failure.
module fa_bist_checker
    import fa_bist_checker_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_sum,
    input  logic             dut_cout,
    output logic             ta,
    output logic             tb,
    output logic             tcin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail,
    output logic             fail_seen
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = ERR_W'(NUM_VECTORS);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    fa_vec_t            vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic               seen_q, seen_d;

    logic               exp_sum_c;
    logic               exp_cout_c;
    logic               mismatch_c;
    logic               launch_c;
    logic               quit_c;

    fa_ref_model u_ref (
        .a    (vec_q.a),
        .b    (vec_q.b),
        .cin  (vec_q.cin),
        .sum  (exp_sum_c),
        .cout (exp_cout_c)
    );

    assign mismatch_c = ({dut_cout, dut_sum} != {exp_cout_c, exp_sum_c});

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state, sequencing and scoring.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        first_d  = first_q;
        seen_d   = seen_q;
        launch_c = 1'b0;
        quit_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                launch_c = start && !abort;
            end
            RUN: begin
                if (abort) begin
                    quit_c = 1'b1;
                end else if (cnt_q <= CNT_W'(1)) begin
                    if (mismatch_c) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!seen_q) begin
                            first_d = idx_q;
                            seen_d  = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        vec_d = idx_to_vec(idx_d);
                        cnt_d = SETTLE_CNT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (abort) begin
                    quit_c = 1'b1;
                end else begin
                    launch_c = start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the scoreboard but parks the stimulus at vector 0.
        if (quit_c) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end

        if (launch_c) begin
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = SETTLE_CNT;
            vec_d   = idx_to_vec('0);
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            first_d = '0;
            seen_d  = 1'b0;
        end
    end

    assign ta         = vec_q.a;
    assign tb         = vec_q.b;
    assign tcin       = vec_q.cin;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_q;
    assign fail_seen  = seen_q;

endmodule

// File: doc/fa_bist_checker.md
FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning clock cycles each vector is held before its response is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock (single clock domain).
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  begin a test run; sampled in IDLE and DONE only.
REQ-005 The block SHALL have port abort  input  1  terminate a run and return to IDLE.
REQ-006 The block SHALL have port dut_sum  input  1  full-adder sum under test.
REQ-007 The block SHALL have port dut_cout  input  1  full-adder carry-out under test.
REQ-008 The block SHALL have ports ta, tb, tcin  output  1 each  registered stimulus to the full-adder a, b, cin.
REQ-009 The block SHALL have port busy  output  1  high in RUN.
REQ-010 The block SHALL have port done  output  1  high in DONE.
REQ-011 The block SHALL have port pass  output  1  valid while done; 1 iff err_count==0.
REQ-012 The block SHALL have port err_count  output  4  number of mismatching vectors in the run (0..8).
REQ-013 The block SHALL have port first_fail  output  3  index of the first failing vector; valid when fail_seen=1.
REQ-014 The block SHALL have port fail_seen  output  1  at least one mismatch recorded in the run.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE.
REQ-016 Vector index idx (3 bits) SHALL map to {ta,tb,tcin} = {idx[2],idx[1],idx[0]}, applied in order 0..7.
REQ-017 Expected response SHALL be {cout,sum} = ta+tb+tcin as a 2-bit sum.
REQ-018 IDLE or DONE with start=1 at edge E0: load idx=0 onto stim, clear err_count/fail_seen/first_fail, set settle counter to SETTLE, go to RUN.
REQ-019 In RUN the settle counter SHALL decrement each edge; the edge on which it reaches the sample point (SETTLE edges after the vector was loaded) compares {dut_cout,dut_sum} against the expected value.
REQ-020 On a mismatch, err_count SHALL increment; if fail_seen=0, first_fail<=idx and fail_seen<=1.
REQ-021 On the sample edge with idx<7, idx SHALL increment, the next vector loads on that same edge, and the counter reloads SETTLE.
REQ-022 On the sample edge with idx==7, the FSM SHALL go to DONE; done therefore rises at edge E0+8*SETTLE.
REQ-023 In DONE, stim SHALL hold vector 7 and all results SHALL hold until the next start.
REQ-024 start while in RUN SHALL be ignored.
REQ-025 abort in RUN or DONE SHALL go to IDLE next edge, drive stim to 0, and leave err_count/first_fail/fail_seen frozen; abort beats start when both are high.
REQ-026 pass SHALL be 0 whenever done=0.
REQ-027 err_count SHALL not exceed 8; no wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, ta=tb=tcin=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0, idx=0, and settle counter=0, including mid-run.
REQ-029 After rst_n is released, the block SHALL stay in IDLE until start.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the vector count 8, and the width of err_count.
REQ-031 Expected-response generation SHALL be a separate combinational sub-module, fa_ref_model (a,b,cin -> sum,cout), instantiated once.

Verification
REQ-032 Correct behavioral full adder, SETTLE=1, start at E0 -> stim steps 000..111 one per cycle; done at E0+8; err_count=0; pass=1; fail_seen=0.
REQ-033 dut_sum stuck at 0 -> err_count=4 (idx 1,2,4,7); first_fail=1; pass=0.
REQ-034 dut_cout inverted, SETTLE=3 -> each vector held 3 cycles; done at E0+24; err_count=8; first_fail=0.
REQ-035 start pulsed at vector 4 during a run -> run unaffected; done still at E0+8*SETTLE.
REQ-036 rst_n low at vector 5 -> all outputs 0 immediately; start after release -> a fresh full run with counts from 0.
REQ-037 abort at vector 3 with one prior error -> IDLE next edge; stim=000; err_count=1 held; done=0; pass=0.
